// File: rtl/uart_loop_fifo_if.sv
// Handshake bundle between the receiver, the loopback FIFO stage and the transmitter.
// The stage itself uses the slave view; whatever drives and observes it uses master.
interface uart_loop_fifo_if #(
  parameter int ADDR_W = 4
) ();

  logic              recv_done;
  logic [7:0]        recv_data;
  logic              tx_busy;
  logic              send_en;
  logic [7:0]        send_data;
  logic [ADDR_W:0]   fifo_count;
  logic              overflow;

  modport master (
    output recv_done, recv_data, tx_busy,
    input  send_en, send_data, fifo_count, overflow
  );

  modport slave (
    input  recv_done, recv_data, tx_busy,
    output send_en, send_data, fifo_count, overflow
  );

endinterface

// File: rtl/uart_loop_fifo.sv
// FIFO-buffered byte loopback between uart_recv and uart_send.
// Every rising edge of recv_done stores one byte; a small FSM drains the FIFO
// one byte per transmitter frame using the tx_busy handshake, with a timeout
// so a request the transmitter never acknowledges cannot stall the stage.
module uart_loop_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic             sys_clk,
  input logic             sys_rst,
  uart_loop_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [ADDR_W:0]   FULL_COUNT   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE      = ADDR_W'(1);
  localparam logic [3:0]        TIMEOUT_LAST = 4'd14;

  state_t            state;
  logic              recv_done_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow_flag;
  logic              send_pulse;
  logic [7:0]        send_byte;
  logic [3:0]        timer;
  logic [7:0]        mem [DEPTH];

  logic wr;
  logic rd;
  logic full;
  logic do_wr;

  // A pop in the same cycle frees a slot, so a write to a full FIFO still succeeds then.
  assign wr    = bus.recv_done & ~recv_done_d;
  assign full  = (count == FULL_COUNT);
  assign rd    = (state == IDLE) && (count != '0) && !bus.tx_busy;
  assign do_wr = wr && (!full || rd);

  assign bus.send_en    = send_pulse;
  assign bus.send_data  = send_byte;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_flag;

  // Byte storage; contents are deliberately left unreset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && do_wr) begin
      mem[wr_ptr] <= bus.recv_data;
    end
  end

  // Edge detect, write pointer, occupancy count and sticky overflow flag.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      recv_done_d   <= 1'b0;
      wr_ptr        <= '0;
      count         <= '0;
      overflow_flag <= 1'b0;
    end else begin
      recv_done_d <= bus.recv_done;
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (wr && !do_wr) begin
        overflow_flag <= 1'b1;
      end
      case ({do_wr, rd})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Drain FSM: pop when idle and the transmitter is free, pulse send_en, then follow tx_busy.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      send_pulse <= 1'b0;
      send_byte  <= 8'h00;
      timer      <= 4'd0;
    end else begin
      send_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (rd) begin
            send_byte  <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + PTR_ONE;
            send_pulse <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= 4'd0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (timer == TIMEOUT_LAST) begin
            state <= IDLE;
          end else begin
            timer <= timer + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Self-checking bench for uart_loop_fifo: a transmitter model answers send_en
// with a busy window, a scoreboard queue holds the bytes expected on send_data
// in arrival order, and a vector table plus directed sequences cover the corners.
module tb_uart_loop_fifo;

  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int BUSY_LEN = 8;

  typedef struct {
    logic [7:0] data;
    int         hold;
    int         cnt_t0;
    int         cnt_t1;
    int         cnt_t2;
    int         send_t1;
    int         send_t2;
  } vec_t;

  logic sys_clk;
  logic sys_rst;

  uart_loop_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_loop_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] sb[$];
  int         send_cnt = 0;
  int         cycle = 0;
  int         last_send_cycle = 0;
  int         prev_send_cycle = 0;
  bit         force_busy = 1'b0;
  bit         tx_model_on = 1'b1;
  int         busy_left = 0;
  int         hold_left = 0;
  vec_t       vecs[4];

  // Free-running clock.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Cycle counter used to measure spacing between send_en pulses.
  always @(posedge sys_clk) begin
    cycle++;
  end

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Transmitter model: busy for a frame after each send_en unless ignoring or forced.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (force_busy) begin
        bus.tx_busy = 1'b1;
        busy_left   = 0;
      end else if (tx_model_on && bus.send_en) begin
        bus.tx_busy = 1'b1;
        busy_left   = BUSY_LEN;
      end else if (busy_left > 0) begin
        busy_left--;
        bus.tx_busy = 1'b1;
      end else begin
        bus.tx_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every send_en must carry the oldest outstanding byte.
  always @(negedge sys_clk) begin
    if (!sys_rst && bus.send_en) begin
      send_cnt++;
      prev_send_cycle = last_send_cycle;
      last_send_cycle = cycle;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_send: got data 0x%0h, expected no send", bus.send_data);
      end else begin
        check_output("send_data_order", int'(bus.send_data), int'(sb.pop_front()));
      end
    end
  end

  // Watchdog so the bench can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got time limit reached, expected test end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input logic [7:0] data, input bit expect_sent);
    @(posedge sys_clk);
    #1;
    bus.recv_done = 1'b1;
    bus.recv_data = data;
    if (expect_sent) sb.push_back(data);
    @(posedge sys_clk);
    #1;
    bus.recv_done = 1'b0;
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) bus.recv_done = 1'b0;
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((bus.fifo_count != 0 || bus.tx_busy || busy_left != 0 || sb.size() != 0)
           && n < max_cycles) begin
      @(negedge sys_clk);
      n++;
    end
    check_output("drain_in_budget", int'(n < max_cycles), 1);
    repeat (4) @(negedge sys_clk);
  endtask

  initial begin
    int s0;
    int n;

    vecs[0] = '{data: 8'hA5, hold: 1, cnt_t0: 0, cnt_t1: 1, cnt_t2: 0, send_t1: 0, send_t2: 1};
    vecs[1] = '{data: 8'h3C, hold: 3, cnt_t0: 0, cnt_t1: 1, cnt_t2: 0, send_t1: 0, send_t2: 1};
    vecs[2] = '{data: 8'hFF, hold: 1, cnt_t0: 0, cnt_t1: 1, cnt_t2: 0, send_t1: 0, send_t2: 1};
    vecs[3] = '{data: 8'h00, hold: 5, cnt_t0: 0, cnt_t1: 1, cnt_t2: 0, send_t1: 0, send_t2: 1};

    // Reset state.
    sys_rst       = 1'b1;
    bus.recv_done = 1'b0;
    bus.recv_data = 8'h00;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_output("reset_send_en", int'(bus.send_en), 0);
    check_output("reset_send_data", int'(bus.send_data), 8'h00);
    check_output("reset_fifo_count", int'(bus.fifo_count), 0);
    check_output("reset_overflow", int'(bus.overflow), 0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Single-byte fill latency, including level-style recv_done held several cycles.
    for (int i = 0; i < 4; i++) begin
      s0 = send_cnt;
      @(posedge sys_clk);
      #1;
      bus.recv_done = 1'b1;
      bus.recv_data = vecs[i].data;
      sb.push_back(vecs[i].data);
      hold_left = vecs[i].hold;
      @(negedge sys_clk);
      check_output("vec_count_t0", int'(bus.fifo_count), vecs[i].cnt_t0);
      step();
      @(negedge sys_clk);
      check_output("vec_count_t1", int'(bus.fifo_count), vecs[i].cnt_t1);
      check_output("vec_send_en_t1", int'(bus.send_en), vecs[i].send_t1);
      step();
      @(negedge sys_clk);
      check_output("vec_send_en_t2", int'(bus.send_en), vecs[i].send_t2);
      check_output("vec_send_data_t2", int'(bus.send_data), int'(vecs[i].data));
      check_output("vec_count_t2", int'(bus.fifo_count), vecs[i].cnt_t2);
      while (hold_left > 0) step();
      wait_drain(200);
      check_output("vec_single_send", send_cnt - s0, 1);
    end

    // Burst while the transmitter is held busy for about 100 cycles.
    $display("[TB] burst");
    s0 = send_cnt;
    force_busy = 1'b1;
    for (int i = 1; i <= 5; i++) apply_stimulus(8'(i), 1'b1);
    @(negedge sys_clk);
    check_output("burst_count", int'(bus.fifo_count), 5);
    repeat (88) @(posedge sys_clk);
    check_output("burst_no_send_while_busy", send_cnt - s0, 0);
    @(posedge sys_clk);
    #1;
    force_busy = 1'b0;
    wait_drain(400);
    check_output("burst_sends", send_cnt - s0, 5);

    // Overflow: seventeen writes into a sixteen-deep FIFO, the last one dropped.
    $display("[TB] overflow");
    s0 = send_cnt;
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) apply_stimulus(8'(8'h80 + i), i < 16);
    @(negedge sys_clk);
    check_output("ovf_count_full", int'(bus.fifo_count), DEPTH);
    check_output("ovf_flag_set", int'(bus.overflow), 1);
    @(posedge sys_clk);
    #1;
    force_busy = 1'b0;
    wait_drain(600);
    check_output("ovf_sends", send_cnt - s0, 16);
    check_output("ovf_flag_sticky", int'(bus.overflow), 1);
    check_output("ovf_count_drained", int'(bus.fifo_count), 0);

    // Reset while waiting for the transmitter with three bytes still queued.
    $display("[TB] reset mid-operation");
    force_busy = 1'b1;
    for (int i = 1; i <= 4; i++) apply_stimulus(8'(8'h11 * i), 1'b1);
    @(negedge sys_clk);
    check_output("rst_count_before", int'(bus.fifo_count), 4);
    s0 = send_cnt;
    @(posedge sys_clk);
    #1;
    force_busy = 1'b0;
    n = 0;
    while (send_cnt == s0 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    check_output("rst_first_send_seen", int'(n < 20), 1);
    repeat (3) @(negedge sys_clk);
    check_output("rst_count_queued", int'(bus.fifo_count), 3);
    check_output("rst_tx_busy_frame", int'(bus.tx_busy), 1);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_output("rst_count_cleared", int'(bus.fifo_count), 0);
    check_output("rst_send_en_low", int'(bus.send_en), 0);
    check_output("rst_overflow_cleared", int'(bus.overflow), 0);
    sb.delete();
    s0 = send_cnt;
    repeat (40) @(negedge sys_clk);
    check_output("rst_no_send_after", send_cnt - s0, 0);
    apply_stimulus(8'h5A, 1'b1);
    wait_drain(100);
    check_output("rst_new_byte_sent", send_cnt - s0, 1);

    // Write into a full FIFO in the same cycle as the idle pop.
    $display("[TB] simultaneous");
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) apply_stimulus(8'(8'hC0 + i), 1'b1);
    @(negedge sys_clk);
    check_output("sim_count_full", int'(bus.fifo_count), DEPTH);
    check_output("sim_overflow_before", int'(bus.overflow), 0);
    s0 = send_cnt;
    @(posedge sys_clk);
    #1;
    force_busy    = 1'b0;
    bus.recv_done = 1'b1;
    bus.recv_data = 8'hEE;
    sb.push_back(8'hEE);
    @(posedge sys_clk);
    #1;
    bus.recv_done = 1'b0;
    @(negedge sys_clk);
    check_output("sim_count_held", int'(bus.fifo_count), DEPTH);
    check_output("sim_overflow_clear", int'(bus.overflow), 0);
    check_output("sim_send_en", int'(bus.send_en), 1);
    check_output("sim_send_data_first", int'(bus.send_data), 8'hC0);
    wait_drain(600);
    check_output("sim_sends", send_cnt - s0, 17);
    check_output("sim_overflow_after", int'(bus.overflow), 0);

    // Transmitter ignores send_en: the stage must time out and issue the next byte.
    $display("[TB] timeout");
    tx_model_on = 1'b0;
    s0 = send_cnt;
    apply_stimulus(8'h6B, 1'b1);
    apply_stimulus(8'h94, 1'b1);
    n = 0;
    while (send_cnt < s0 + 2 && n < 60) begin
      @(negedge sys_clk);
      n++;
    end
    check_output("tmo_both_sent", send_cnt - s0, 2);
    check_output("tmo_send_gap", last_send_cycle - prev_send_cycle, 17);
    repeat (20) @(negedge sys_clk);
    check_output("tmo_queue_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
